// File: rtl/mfm_sync_detector_multi.sv
// mfm_sync_detector_multi
// Assembles an MFM bit stream from flux/window strobes and detects a run of
// back-to-back, bit-aligned matches against a masked sync pattern.
//
// Ports:
//   i_clk_pll32mhz        master clock, all state on rising edge
//   i_reset               asynchronous active-high reset
//   i_enable              low = synchronous clear of all state
//   i_flux_pulse          one-cycle pulse, flux transition seen
//   i_window_tick         one-cycle pulse, bit cell boundary
//   i_sync_word_in        pattern to match
//   i_sync_mask_in        1 = bit participates in comparison
//   i_repeat_in           consecutive matches required (0 treated as 1)
//   i_unlock              one-cycle pulse, clears o_sync_locked
//   o_sync_word_detected  one-cycle pulse on completed sync run
//   o_sync_locked         level, set on detection
//   o_match_count         current consecutive-match count
//   o_shift_data          shift register contents (debug)
module mfm_sync_detector_multi #(
  parameter int unsigned SYNC_WIDTH   = 16,
  parameter int unsigned MAX_ERRORS   = 0,
  parameter int unsigned REPEAT_WIDTH = 4
) (
  input  logic                    i_clk_pll32mhz,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_flux_pulse,
  input  logic                    i_window_tick,
  input  logic [SYNC_WIDTH-1:0]   i_sync_word_in,
  input  logic [SYNC_WIDTH-1:0]   i_sync_mask_in,
  input  logic [REPEAT_WIDTH-1:0] i_repeat_in,
  input  logic                    i_unlock,
  output logic                    o_sync_word_detected,
  output logic                    o_sync_locked,
  output logic [REPEAT_WIDTH-1:0] o_match_count,
  output logic [SYNC_WIDTH-1:0]   o_shift_data
);

  localparam int unsigned CntW = $clog2(SYNC_WIDTH + 2);
  localparam int unsigned ErrW = $clog2(SYNC_WIDTH + 1);
  localparam logic [CntW-1:0] FillMax = CntW'(SYNC_WIDTH);
  localparam logic [CntW-1:0] RunMax  = CntW'(SYNC_WIDTH + 1);
  localparam logic [REPEAT_WIDTH-1:0] McMax = '1;
  localparam logic [REPEAT_WIDTH-1:0] McOne = REPEAT_WIDTH'(1);
  localparam logic [ErrW-1:0] ErrLimit = ErrW'(MAX_ERRORS);

  logic                    r_flux_latch, r_flux_latch_d;
  logic [SYNC_WIDTH-1:0]   r_sr, r_sr_d;
  logic [CntW-1:0]         r_fill, r_fill_d;
  logic [CntW-1:0]         r_bsm, r_bsm_d;    // bits since last match
  logic                    r_eval, r_eval_d;  // sr was shifted on the previous edge
  logic [REPEAT_WIDTH-1:0] r_mc, r_mc_d;
  logic                    r_det, r_det_d;
  logic                    r_locked, r_locked_d;

  logic                    w_bit;
  logic [SYNC_WIDTH-1:0]   w_diff;
  logic [ErrW-1:0]         w_err;
  logic                    w_match;
  logic [REPEAT_WIDTH-1:0] w_rep_eff;
  logic [REPEAT_WIDTH-1:0] w_inc;
  logic                    w_detect;

  assign w_bit     = r_flux_latch | i_flux_pulse;
  assign w_diff    = (r_sr ^ i_sync_word_in) & i_sync_mask_in;
  assign w_rep_eff = (i_repeat_in == '0) ? McOne : i_repeat_in;

  always_comb begin
    w_err = '0;
    for (int i = 0; i < SYNC_WIDTH; i++) begin
      w_err = w_err + ErrW'(w_diff[i]);
    end
  end

  // Cleared zeros never match: compare only once a full word has shifted in.
  assign w_match = (r_fill == FillMax) && (w_err <= ErrLimit);

  always_comb begin
    r_flux_latch_d = r_flux_latch;
    r_sr_d         = r_sr;
    r_fill_d       = r_fill;
    r_bsm_d        = r_bsm;
    r_eval_d       = i_window_tick;
    r_mc_d         = r_mc;
    r_locked_d     = r_locked;
    w_inc          = r_mc;
    w_detect       = 1'b0;

    if (i_window_tick) begin
      r_sr_d         = {r_sr[SYNC_WIDTH-2:0], w_bit};
      r_flux_latch_d = 1'b0;
      r_fill_d       = (r_fill == FillMax) ? r_fill : r_fill + 1'b1;
      r_bsm_d        = (r_bsm == RunMax) ? r_bsm : r_bsm + 1'b1;
    end else if (i_flux_pulse) begin
      r_flux_latch_d = 1'b1;
    end

    if (r_eval && w_match) begin
      // Aligned continuation of a run, or the first match of one.
      if ((r_mc == '0) || (r_bsm == FillMax)) begin
        w_inc = (r_mc == McMax) ? r_mc : r_mc + 1'b1;
      end else begin
        w_inc = McOne;
      end
      // >= so that lowering the repeat target mid-run fires on the next match.
      if (w_inc >= w_rep_eff) begin
        w_detect = 1'b1;
        r_mc_d   = '0;
      end else begin
        r_mc_d   = w_inc;
      end
      // A tick on this same edge is the first bit of the next word.
      r_bsm_d = i_window_tick ? CntW'(1) : '0;
    end else if (r_bsm == RunMax) begin
      r_mc_d = '0;
    end

    if (w_detect) begin
      r_locked_d = 1'b1;
    end else if (i_unlock) begin
      r_locked_d = 1'b0;
    end
    r_det_d = w_detect;

    if (!i_enable) begin
      r_flux_latch_d = 1'b0;
      r_sr_d         = '0;
      r_fill_d       = '0;
      r_bsm_d        = '0;
      r_eval_d       = 1'b0;
      r_mc_d         = '0;
      r_det_d        = 1'b0;
      r_locked_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk_pll32mhz or posedge i_reset) begin
    if (i_reset) begin
      r_flux_latch <= 1'b0;
      r_sr         <= '0;
      r_fill       <= '0;
      r_bsm        <= '0;
      r_eval       <= 1'b0;
      r_mc         <= '0;
      r_det        <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_flux_latch <= r_flux_latch_d;
      r_sr         <= r_sr_d;
      r_fill       <= r_fill_d;
      r_bsm        <= r_bsm_d;
      r_eval       <= r_eval_d;
      r_mc         <= r_mc_d;
      r_det        <= r_det_d;
      r_locked     <= r_locked_d;
    end
  end

  assign o_sync_word_detected = r_det;
  assign o_sync_locked        = r_locked;
  assign o_match_count        = r_mc;
  assign o_shift_data         = r_sr;

endmodule

// File: tb/tb_mfm_sync_detector_multi.sv
module tb_mfm_sync_detector_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flux = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] sync_w = 16'h4489;
  logic [15:0] mask_w = 16'hFFFF;
  logic [3:0]  rep = 4'd1;
  logic        unlock = 1'b0;

  logic        det0, lock0, det1, lock1;
  logic [3:0]  mc0, mc1;
  logic [15:0] sd0, sd1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk1 = 1'b1;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfm_sync_detector_multi #(.SYNC_WIDTH(16), .MAX_ERRORS(0), .REPEAT_WIDTH(4)) dut0 (
    .i_clk_pll32mhz(clk), .i_reset(rst), .i_enable(en), .i_flux_pulse(flux),
    .i_window_tick(tick), .i_sync_word_in(sync_w), .i_sync_mask_in(mask_w),
    .i_repeat_in(rep), .i_unlock(unlock), .o_sync_word_detected(det0),
    .o_sync_locked(lock0), .o_match_count(mc0), .o_shift_data(sd0)
  );

  mfm_sync_detector_multi #(.SYNC_WIDTH(16), .MAX_ERRORS(1), .REPEAT_WIDTH(4)) dut1 (
    .i_clk_pll32mhz(clk), .i_reset(rst), .i_enable(en), .i_flux_pulse(flux),
    .i_window_tick(tick), .i_sync_word_in(sync_w), .i_sync_mask_in(mask_w),
    .i_repeat_in(rep), .i_unlock(unlock), .o_sync_word_detected(det1),
    .o_sync_locked(lock1), .o_match_count(mc1), .o_shift_data(sd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse scoreboard: each expected pulse is queued with the cycle it must appear in.
  always @(negedge clk) begin
    if (!rst && det0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL pulse0 unexpected actual_cyc=%0d required=none", cyc);
      end else begin
        automatic int e = q0.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL pulse0 timing actual_cyc=%0d required_cyc=%0d", cyc, e);
        end
      end
    end
    if (!rst && chk1 && det1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL pulse1 unexpected actual_cyc=%0d required=none", cyc);
      end else begin
        automatic int e = q1.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL pulse1 timing actual_cyc=%0d required_cyc=%0d", cyc, e);
        end
      end
    end
  end

  // mode 0: flux coincident with tick; mode 1: flux pulsed twice earlier in the window.
  task automatic drive_bit(input logic b, input int mode, input bit p0, input bit p1);
    if (mode == 1) begin
      @(negedge clk); tick = 1'b0; flux = b;
      @(negedge clk); flux = 1'b0;
      @(negedge clk); flux = b;
      @(negedge clk); flux = 1'b0; tick = 1'b1;
    end else begin
      @(negedge clk); flux = b; tick = 1'b1;
    end
    @(posedge clk);
    #1;
    if (p0) q0.push_back(cyc + 1);
    if (p1) q1.push_back(cyc + 1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit p0);
    for (int b = 15; b >= 0; b--) drive_bit(w[b], b % 2, p0 && (b == 0), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b0; flux = 1'b0;
    end
  endtask

  task automatic enable_cycle();
    @(negedge clk); en = 1'b0; tick = 1'b0; flux = 1'b0;
    @(negedge clk); en = 1'b1;
    q0.delete(); q1.delete();
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] sync;
    logic [15:0] mask;
    logic [3:0]  rep;
    bit          exp0;
    bit          exp1;
    logic [3:0]  mc0;
    logic [3:0]  mc1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h4489, 16'h4489, 16'hFFFF, 4'd1, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[1] = '{16'h4488, 16'h4489, 16'hFFFF, 4'd1, 1'b0, 1'b1, 4'd0, 4'd0};
    vecs[2] = '{16'h448A, 16'h4489, 16'hFFFF, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[3] = '{16'h448F, 16'h4489, 16'hFFF0, 4'd1, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[4] = '{16'h0000, 16'h0000, 16'hFFFF, 4'd1, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[5] = '{16'h1234, 16'h4489, 16'hFFFF, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[6] = '{16'h4489, 16'h4489, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[7] = '{16'h4489, 16'h4489, 16'hFFFF, 4'd2, 1'b0, 1'b0, 4'd1, 4'd1};

    // Reset state
    #3;
    chk("rst_det", {31'd0, det0}, 32'd0);
    chk("rst_lock", {31'd0, lock0}, 32'd0);
    chk("rst_mc", {28'd0, mc0}, 32'd0);
    chk("rst_shift", {16'd0, sd0}, 32'd0);
    @(negedge clk); rst = 1'b0; en = 1'b1;

    // Single-word table
    chk1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enable_cycle();
      sync_w = vecs[i].sync; mask_w = vecs[i].mask; rep = vecs[i].rep;
      for (int b = 15; b >= 0; b--) begin
        drive_bit(vecs[i].word[b], b % 2, vecs[i].exp0 && (b == 0), vecs[i].exp1 && (b == 0));
      end
      idle(3);
      chk($sformatf("v%0d_missing0", i), q0.size(), 32'd0);
      chk($sformatf("v%0d_missing1", i), q1.size(), 32'd0);
      chk($sformatf("v%0d_shift", i), {16'd0, sd0}, {16'd0, vecs[i].word});
      chk($sformatf("v%0d_mc0", i), {28'd0, mc0}, {28'd0, vecs[i].mc0});
      chk($sformatf("v%0d_mc1", i), {28'd0, mc1}, {28'd0, vecs[i].mc1});
      chk($sformatf("v%0d_lock0", i), {31'd0, lock0}, {31'd0, vecs[i].exp0});
      chk($sformatf("v%0d_lock1", i), {31'd0, lock1}, {31'd0, vecs[i].exp1});
    end

    chk1 = 1'b0;
    sync_w = 16'h4489; mask_w = 16'hFFFF;

    // Triple sync
    enable_cycle(); rep = 4'd3;
    send_word(16'h4489, 1'b0); idle(2);
    chk("triple_mc1", {28'd0, mc0}, 32'd1);
    send_word(16'h4489, 1'b0); idle(2);
    chk("triple_mc2", {28'd0, mc0}, 32'd2);
    chk("triple_nolock", {31'd0, lock0}, 32'd0);
    send_word(16'h4489, 1'b1); idle(3);
    chk("triple_missing", q0.size(), 32'd0);
    chk("triple_mc0", {28'd0, mc0}, 32'd0);
    chk("triple_lock", {31'd0, lock0}, 32'd1);

    // Extra bit between words 2 and 3 breaks alignment
    enable_cycle(); rep = 4'd3;
    send_word(16'h4489, 1'b0); idle(1);
    send_word(16'h4489, 1'b0); idle(1);
    drive_bit(1'b0, 0, 1'b0, 1'b0);
    send_word(16'h4489, 1'b0); idle(3);
    chk("misalign_mc", {28'd0, mc0}, 32'd1);
    chk("misalign_nolock", {31'd0, lock0}, 32'd0);

    // Async reset mid-run
    enable_cycle(); rep = 4'd3;
    send_word(16'h4489, 1'b0); send_word(16'h4489, 1'b0); idle(2);
    chk("prerst_mc", {28'd0, mc0}, 32'd2);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_mc", {28'd0, mc0}, 32'd0);
    chk("midrst_shift", {16'd0, sd0}, 32'd0);
    chk("midrst_lock", {31'd0, lock0}, 32'd0);
    chk("midrst_det", {31'd0, det0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    q0.delete(); q1.delete();

    // Fill guard with ENABLE low mid-run: zero pattern needs a full 16-bit refill
    enable_cycle(); rep = 4'd1; sync_w = 16'h0000;
    for (int b = 0; b < 10; b++) drive_bit(1'b0, b % 2, 1'b0, 1'b0);
    enable_cycle();
    chk("en_mc", {28'd0, mc0}, 32'd0);
    for (int b = 0; b < 15; b++) drive_bit(1'b0, b % 2, 1'b0, 1'b0);
    idle(3);
    chk("fill15_nolock", {31'd0, lock0}, 32'd0);
    drive_bit(1'b0, 0, 1'b1, 1'b0);
    idle(3);
    chk("fill16_missing", q0.size(), 32'd0);
    chk("fill16_lock", {31'd0, lock0}, 32'd1);

    // UNLOCK racing detection, then UNLOCK alone
    enable_cycle(); rep = 4'd1; sync_w = 16'h4489;
    for (int b = 15; b >= 1; b--) drive_bit(sync_w[b], b % 2, 1'b0, 1'b0);
    @(negedge clk); flux = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    q0.push_back(cyc + 1);
    tick = 1'b0; flux = 1'b0; unlock = 1'b1;
    @(posedge clk); #1;
    unlock = 1'b0;
    chk("race_lock", {31'd0, lock0}, 32'd1);
    idle(2);
    chk("race_missing", q0.size(), 32'd0);
    @(negedge clk); unlock = 1'b1;
    @(posedge clk); #1;
    unlock = 1'b0;
    chk("unlock_lock", {31'd0, lock0}, 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfm_sync_detector_multi.md
Name: mfm_sync_detector_multi

Overview:
- Parametrised, fully synchronous successor to the single-word MFM sync detector.
- Takes one-cycle flux and window-boundary strobes from an upstream data separator/synchroniser and assembles the MFM bit stream in a SYNC_WIDTH-bit shift register.
- Compares against a masked sync pattern with a tolerated bit-error count; only a run of REPEAT_IN back-to-back, bit-aligned matches counts as a sync (e.g. 3 x 0x4489).
- Feeds the track-acquisition / byte-framing logic.

Parameters:
SYNC_WIDTH, 16, shift register and pattern width in bits (>=8)
MAX_ERRORS, 0, maximum masked bit mismatches still counted as a match (0..SYNC_WIDTH-1)
REPEAT_WIDTH, 4, width of REPEAT_IN and MATCH_COUNT

Ports:
CLK_PLL32MHZ  in  1  master clock; all state on rising edge
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  detector enable; low = synchronous clear of all state
FLUX_PULSE  in  1  one-cycle pulse: flux transition seen
WINDOW_TICK  in  1  one-cycle pulse: data window boundary (bit cell end)
SYNC_WORD_IN  in  SYNC_WIDTH  pattern to match
SYNC_MASK_IN  in  SYNC_WIDTH  1 = bit participates in comparison
REPEAT_IN  in  REPEAT_WIDTH  consecutive matches required; 0 treated as 1
UNLOCK  in  1  one-cycle pulse: clear SYNC_LOCKED
SYNC_WORD_DETECTED  out  1  one-cycle pulse on completed sync run
SYNC_LOCKED  out  1  level: set by detection, held until UNLOCK/ENABLE low
MATCH_COUNT  out  REPEAT_WIDTH  current consecutive-match count
SHIFT_DATA  out  SYNC_WIDTH  current shift register contents (debug)

Behaviour:
- RESET high (async): all registers 0; all outputs 0.
- ENABLE low: same clear, applied synchronously on the next edge; inputs are ignored while low.
- Flux latch:
  - FLUX_PULSE sets flux_latch.
  - On WINDOW_TICK: shift in bit = flux_latch | FLUX_PULSE, then clear flux_latch. A simultaneous pulse and tick counts in the closing window.
  - FLUX_PULSE repeats within a window are idempotent.
- Shift: on WINDOW_TICK, sr <= {sr[SYNC_WIDTH-2:0], bit}.
- Counters:
  - fill counter saturates at SYNC_WIDTH; comparison is suppressed until SYNC_WIDTH bits have shifted since reset/enable (no match on cleared zeros).
  - bits_since_match increments per tick and saturates at SYNC_WIDTH+1.
- Compare (registered, evaluated on the cycle after the shifting edge): err = popcount((sr ^ SYNC_WORD_IN) & SYNC_MASK_IN); match = filled && err <= MAX_ERRORS. Match is evaluated once per shifted bit only.
- Repeat logic, on each evaluated match:
  - If MATCH_COUNT==0, or bits_since_match==SYNC_WIDTH: MATCH_COUNT++ and bits_since_match <= 0.
  - Otherwise (overlapping/misaligned match): MATCH_COUNT <= 1, bits_since_match <= 0.
- Run broken: if bits_since_match reaches SYNC_WIDTH+1 with no match, MATCH_COUNT <= 0.
- Detection:
  - When the incremented count equals max(REPEAT_IN,1), SYNC_WORD_DETECTED pulses for exactly one cycle, SYNC_LOCKED <= 1, and MATCH_COUNT <= 0 (a new full run is needed to pulse again).
  - Latency: tick at edge k shifts at edge k; pulse is high for the cycle after edge k+1.
- SYNC_LOCKED: set by detection and cleared by UNLOCK. Detection and UNLOCK in the same cycle leaves it set.
- MATCH_COUNT saturates at 2^REPEAT_WIDTH-1. It never wraps.
- Config inputs may change at any time and take effect on the next comparison. Changing REPEAT_IN below the current MATCH_COUNT does not fire detection until the next match.
- WINDOW_TICK on consecutive cycles is legal. Each tick shifts one bit and produces one comparison.

Test Plan:
- Single-word hit: REPEAT_IN=1, MAX_ERRORS=0, mask 0xFFFF, stream 0x4489 MSB-first with a tick per bit -> SYNC_WORD_DETECTED one cycle, two edges after the last tick; SYNC_LOCKED=1; SHIFT_DATA=0x4489.
- Triple sync: REPEAT_IN=3, stream 0x4489 x3 back-to-back -> MATCH_COUNT 1,2 then one pulse after the third word. Insert one extra bit between words 2 and 3 -> MATCH_COUNT restarts at 1, no pulse.
- Error tolerance: MAX_ERRORS=1, stream 0x4488 -> pulse; stream 0x448A (2 errors) -> no pulse. Mask 0xFFF0 with stream 0x448F and MAX_ERRORS=0 -> pulse.
- Fill guard and flux timing: SYNC_WORD_IN=0 after reset, 15 zero bits -> no pulse; 16th -> pulse. FLUX_PULSE coincident with WINDOW_TICK -> bit=1 enters the closing window.
- Reset/enable mid-run: RESET asserted after 2 of 3 sync words -> all outputs 0 immediately. ENABLE low 1 cycle mid-run -> counters cleared, refill of 16 bits required.
- UNLOCK race: UNLOCK and detection in the same cycle -> SYNC_LOCKED=1. UNLOCK alone -> SYNC_LOCKED=0 next cycle.
